// File: rtl/acq_readout_sequencer.sv
// Capture-and-readout sequencer: triggers the ADC capture block, waits for a fresh data_ready and
// streams the enabled channels' sample bytes. Define ACQ_READOUT_HEADER_EN to prepend a 4-byte header.
module acq_readout_sequencer #(
  parameter int RAM_WIDTH = 10
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 arm,
  input  logic                 cont,
  input  logic                 abort,
  input  logic [3:0]           chmask,
  input  logic [RAM_WIDTH-1:0] triggerpoint,
  input  logic [RAM_WIDTH-1:0] nsmp,
  output logic                 start_trigger,
  input  logic                 data_ready,
  input  logic [RAM_WIDTH-1:0] trig_addr,
  output logic                 rden,
  output logic [RAM_WIDTH-1:0] rdaddress,
  input  logic [31:0]          ram_q,
  output logic [7:0]           tx_data,
  output logic                 tx_valid,
  input  logic                 tx_ready,
  output logic                 busy,
  output logic                 done
);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_WAITLO, S_WAITHI, S_HDR, S_READ, S_DRAIN, S_DONE
  } state_t;

  localparam logic [RAM_WIDTH-1:0] ONE = RAM_WIDTH'(1);

  state_t               state;
  logic [3:0]           mask_r;
  logic [3:0]           rem_r;
  logic [RAM_WIDTH-1:0] tp_r;
  logic [RAM_WIDTH-1:0] nsmp_r;
  logic [RAM_WIDTH-1:0] base_r;
  logic [RAM_WIDTH-1:0] cnt_r;
  logic                 rd_vld_p1;
  logic [1:0]           rd_ch_p1;
  logic [7:0]           buf0;
  logic [7:0]           buf1;
  logic [1:0]           occ;

  logic [1:0]           cur_ch;
  logic [3:0]           rem_nx;
  logic                 pop;
  logic                 space;
  logic                 rd_go;
  logic                 last_smp;
  logic                 push;
  logic                 hdr_push;
  logic [7:0]           lane;
  logic [7:0]           push_data;

  function automatic logic [1:0] low_ch(input logic [3:0] m);
    if (m[0])      return 2'd0;
    else if (m[1]) return 2'd1;
    else if (m[2]) return 2'd2;
    else           return 2'd3;
  endfunction

  assign cur_ch    = low_ch(rem_r);
  assign rem_nx    = rem_r & ~(4'b0001 << cur_ch);
  assign pop       = tx_valid && tx_ready;
  // Credit counts the byte leaving this cycle so a full-rate stream never stalls the reads.
  assign space     = ({1'b0, occ} + {2'b00, rd_vld_p1}) < (3'd2 + {2'b00, pop});
  assign rd_go     = (state == S_READ) && (rem_r != 4'd0) && (nsmp_r != '0);
  assign rden      = rd_go && space;
  assign rdaddress = base_r + cnt_r;
  assign last_smp  = (cnt_r == nsmp_r - ONE);
  assign lane      = ram_q[{rd_ch_p1, 3'b000} +: 8];
  assign push      = rd_vld_p1 || hdr_push;
  assign tx_valid  = (occ != 2'd0);
  assign tx_data   = buf0;

`ifdef ACQ_READOUT_HEADER_EN
  logic [1:0]           hdr_idx;
  logic [RAM_WIDTH-1:0] trig_r;
  logic [15:0]          trig16;
  logic [7:0]           hdr_byte;

  assign trig16 = 16'(trig_r);

  always_comb begin
    hdr_byte = 8'hA5;
    case (hdr_idx)
      2'd1:    hdr_byte = {4'b0000, mask_r};
      2'd2:    hdr_byte = trig16[7:0];
      2'd3:    hdr_byte = trig16[15:8];
      default: hdr_byte = 8'hA5;
    endcase
  end

  assign hdr_push  = (state == S_HDR) && ((occ != 2'd2) || pop);
  assign push_data = rd_vld_p1 ? lane : hdr_byte;
`else
  assign hdr_push  = 1'b0;
  assign push_data = lane;
`endif

  // Capture parameters and datapath registers that need no reset.
  always_ff @(posedge clk) begin
    if (state == S_IDLE && arm) begin
      mask_r <= chmask;
      tp_r   <= triggerpoint;
      nsmp_r <= nsmp;
    end
`ifdef ACQ_READOUT_HEADER_EN
    if (state == S_WAITHI && data_ready) trig_r <= trig_addr;
`endif
    rd_ch_p1 <= cur_ch;
    if (push && ((pop && occ == 2'd2) || (!pop && occ != 2'd0))) buf1 <= push_data;
  end

  // Read-return stage and 2-entry output buffer; abort drops everything in flight.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_vld_p1 <= 1'b0;
      occ       <= 2'd0;
      buf0      <= 8'h00;
    end else begin
      rd_vld_p1 <= rden && !abort;
      if (abort) begin
        occ <= 2'd0;
      end else if (push && pop) begin
        buf0 <= (occ == 2'd1) ? push_data : buf1;
      end else if (pop) begin
        buf0 <= buf1;
        occ  <= occ - 2'd1;
      end else if (push) begin
        if (occ == 2'd0) buf0 <= push_data;
        occ <= occ + 2'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state         <= S_IDLE;
      start_trigger <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      rem_r         <= 4'd0;
      base_r        <= '0;
      cnt_r         <= '0;
`ifdef ACQ_READOUT_HEADER_EN
      hdr_idx       <= 2'd0;
`endif
    end else begin
      start_trigger <= 1'b0;
      done          <= 1'b0;
      if (abort) begin
        state <= S_IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          S_IDLE: if (arm) begin
            state         <= S_START;
            start_trigger <= 1'b1;
            busy          <= 1'b1;
          end
          S_START: state <= S_WAITLO;
          // A flag still high from the previous capture must fall before it counts.
          S_WAITLO: if (!data_ready) state <= S_WAITHI;
          S_WAITHI: if (data_ready) begin
            base_r <= trig_addr - tp_r;
            rem_r  <= mask_r;
            cnt_r  <= '0;
`ifdef ACQ_READOUT_HEADER_EN
            hdr_idx <= 2'd0;
            state   <= S_HDR;
`else
            state   <= S_READ;
`endif
          end
`ifdef ACQ_READOUT_HEADER_EN
          S_HDR: if (hdr_push) begin
            hdr_idx <= hdr_idx + 2'd1;
            if (hdr_idx == 2'd3) state <= S_READ;
          end
`endif
          S_READ: begin
            if (!rd_go) begin
              state <= S_DRAIN;
            end else if (rden) begin
              if (last_smp) begin
                cnt_r <= '0;
                rem_r <= rem_nx;
                if (rem_nx == 4'd0) state <= S_DRAIN;
              end else begin
                cnt_r <= cnt_r + ONE;
              end
            end
          end
          S_DRAIN: if (!rd_vld_p1 && (occ == 2'd0 || (occ == 2'd1 && pop))) begin
            state <= S_DONE;
            done  <= 1'b1;
          end
          S_DONE: if (cont) begin
            state         <= S_START;
            start_trigger <= 1'b1;
          end else begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
